// File: rtl/id_stage_hs_pkg.sv
// id_stage_hs_pkg: opcodes, ALU codes, decoded-instruction record and RV32I decoder
package id_stage_hs_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // ALU code is {sub/sra bit, funct3}; PASSB forwards operand B (LUI)
  localparam logic [3:0] ALU_ADD   = 4'h0;
  localparam logic [3:0] ALU_SUB   = 4'h8;
  localparam logic [3:0] ALU_PASSB = 4'hf;

  typedef enum logic [2:0] {FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  // unused source fields are zeroed so they never match a hazard or forward
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_wen;
    logic        mem_read;
    logic        sel_imm;
    logic        ill;
    logic [3:0]  alu_op;
    logic [31:0] imm;
  } dec_t;

  function automatic logic [31:0] imm_gen(input fmt_e f, input logic [31:0] i);
    return f == FMT_I ? {{20{i[31]}}, i[31:20]} :
           f == FMT_S ? {{20{i[31]}}, i[31:25], i[11:7]} :
           f == FMT_B ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
           f == FMT_U ? {i[31:12], 12'b0} :
           f == FMT_J ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} : '0;
  endfunction

  function automatic dec_t decode(input logic [31:0] i);
    dec_t d;
    fmt_e fmt;
    logic [6:0] f7;
    logic [2:0] f3;
    d   = '0;
    fmt = FMT_NONE;
    f7  = i[31:25];
    f3  = i[14:12];
    case (i[6:0])
      OPC_LUI:    begin d.rd = i[11:7]; d.reg_wen = 1'b1; d.sel_imm = 1'b1; d.alu_op = ALU_PASSB; fmt = FMT_U; end
      OPC_AUIPC:  begin d.rd = i[11:7]; d.reg_wen = 1'b1; d.sel_imm = 1'b1; fmt = FMT_U; end
      OPC_JAL:    begin d.rd = i[11:7]; d.reg_wen = 1'b1; fmt = FMT_J; end
      OPC_JALR:   begin d.rs1 = i[19:15]; d.rd = i[11:7]; d.reg_wen = 1'b1; d.sel_imm = 1'b1; fmt = FMT_I; d.ill = f3 != 3'd0; end
      OPC_BRANCH: begin d.rs1 = i[19:15]; d.rs2 = i[24:20]; d.alu_op = ALU_SUB; fmt = FMT_B; d.ill = f3[2:1] == 2'b01; end
      OPC_LOAD:   begin d.rs1 = i[19:15]; d.rd = i[11:7]; d.reg_wen = 1'b1; d.mem_read = 1'b1; d.sel_imm = 1'b1; fmt = FMT_I; d.ill = f3 == 3'd3 || f3[2:1] == 2'b11; end
      OPC_STORE:  begin d.rs1 = i[19:15]; d.rs2 = i[24:20]; d.sel_imm = 1'b1; fmt = FMT_S; d.ill = f3 > 3'd2; end
      OPC_OP_IMM: begin
        d.rs1 = i[19:15]; d.rd = i[11:7]; d.reg_wen = 1'b1; d.sel_imm = 1'b1; fmt = FMT_I;
        d.alu_op = {f3 == 3'd5 && i[30], f3};
        d.ill = (f3 == 3'd1 && f7 != 7'd0) || (f3 == 3'd5 && (f7 & 7'b1011111) != 7'd0);
      end
      OPC_OP:     begin
        d.rs1 = i[19:15]; d.rs2 = i[24:20]; d.rd = i[11:7]; d.reg_wen = 1'b1;
        d.alu_op = {i[30], f3};
        d.ill = !(f7 == 7'd0 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default:    d.ill = 1'b1;
    endcase
    d.imm      = imm_gen(fmt, i);
    d.reg_wen  = d.reg_wen && d.rd != 5'd0 && !d.ill;
    d.mem_read = d.mem_read && !d.ill;
    return d;
  endfunction

endpackage

// File: rtl/id_stage_hs_hazard_unit.sv
// id_stage_hs_hazard_unit: load-use hazard and x0-safe forwarding selects; load-use detection enabled by ID_LOAD_USE_STALL_EN
module id_stage_hs_hazard_unit #(
  parameter int RF_AW = 5
) (
  input  logic [RF_AW-1:0] rs1_i,
  input  logic [RF_AW-1:0] rs2_i,
  input  logic             ex_valid_i,
  input  logic             ex_wen_i,
  input  logic             ex_mem_read_i,
  input  logic [RF_AW-1:0] ex_waddr_i,
  input  logic             mem_wen_i,
  input  logic [RF_AW-1:0] mem_waddr_i,
  output logic             hazard_o,
  output logic             rs1_fwd_mem_o,
  output logic             rs1_fwd_wb_o,
  output logic             rs2_fwd_mem_o,
  output logic             rs2_fwd_wb_o
);

`ifdef ID_LOAD_USE_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic rs1_hit_ex, rs2_hit_ex;

  assign rs1_hit_ex    = |rs1_i && rs1_i == ex_waddr_i;
  assign rs2_hit_ex    = |rs2_i && rs2_i == ex_waddr_i;
  assign hazard_o      = STALL_EN && ex_valid_i && ex_mem_read_i && |ex_waddr_i && (rs1_hit_ex || rs2_hit_ex);
  assign rs1_fwd_mem_o = rs1_hit_ex && ex_wen_i && ex_valid_i;
  assign rs2_fwd_mem_o = rs2_hit_ex && ex_wen_i && ex_valid_i;
  assign rs1_fwd_wb_o  = |rs1_i && rs1_i == mem_waddr_i && mem_wen_i && !rs1_fwd_mem_o;
  assign rs2_fwd_wb_o  = |rs2_i && rs2_i == mem_waddr_i && mem_wen_i && !rs2_fwd_mem_o;

endmodule

// File: rtl/id_stage_hs.sv
// id_stage_hs: decode stage with valid/ready handshake, write-through regfile, forwarding flags, load-use bubble (ID_LOAD_USE_STALL_EN)
module id_stage_hs
  import id_stage_hs_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RF_AW    = 5,
  parameter int IMM_W    = 32,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if2id_valid,
  input  logic [XLEN-1:0]     if2id_pc,
  input  logic [31:0]         if2id_instruction,
  output logic                id_ready,
  input  logic                ex_stall,
  input  logic                flush,
  input  logic [RF_AW-1:0]    ex2mem_reg_waddr,
  input  logic                ex2mem_reg_wen,
  input  logic                reg_wen,
  input  logic [RF_AW-1:0]    reg_waddr,
  input  logic [XLEN-1:0]     reg_wdata,
  output logic                id2ex_valid,
  output logic [XLEN-1:0]     id2ex_pc,
  output logic                id2ex_reg_wen,
  output logic [RF_AW-1:0]    id2ex_reg_waddr,
  output logic                id2ex_mem_read,
  output logic [XLEN-1:0]     id2ex_reg_rs1_data,
  output logic [XLEN-1:0]     id2ex_reg_rs2_data,
  output logic [IMM_W-1:0]    id2ex_imm_value,
  output logic [ALU_OP_W-1:0] id2ex_alu_op,
  output logic                id2ex_sel_imm,
  output logic                id2ex_rs1_forward_from_mem,
  output logic                id2ex_rs1_forward_from_wb,
  output logic                id2ex_rs2_forward_from_mem,
  output logic                id2ex_rs2_forward_from_wb,
  output logic                id2ex_ill_instr
);

  dec_t                dec;
  logic [RF_AW-1:0]    rs1, rs2, rd;
  logic [XLEN-1:0]     rf_q [2**RF_AW];
  logic [XLEN-1:0]     rs1_data, rs2_data;
  logic                hazard, f1m, f1w, f2m, f2w, valid_d;
  logic                valid_q, wen_q, mem_read_q, sel_imm_q, ill_q, f1m_q, f1w_q, f2m_q, f2w_q;
  logic [XLEN-1:0]     pc_q, rs1_data_q, rs2_data_q;
  logic [RF_AW-1:0]    waddr_q;
  logic [IMM_W-1:0]    imm_q;
  logic [ALU_OP_W-1:0] alu_op_q;

  assign dec      = decode(if2id_instruction);
  assign rs1      = RF_AW'(dec.rs1);
  assign rs2      = RF_AW'(dec.rs2);
  assign rd       = RF_AW'(dec.rd);
  assign rs1_data = ~|rs1 ? '0 : (reg_wen && reg_waddr == rs1) ? reg_wdata : rf_q[rs1];
  assign rs2_data = ~|rs2 ? '0 : (reg_wen && reg_waddr == rs2) ? reg_wdata : rf_q[rs2];

  id_stage_hs_hazard_unit #(.RF_AW(RF_AW)) u_hazard (
    .rs1_i         (rs1),
    .rs2_i         (rs2),
    .ex_valid_i    (valid_q),
    .ex_wen_i      (wen_q),
    .ex_mem_read_i (mem_read_q),
    .ex_waddr_i    (waddr_q),
    .mem_wen_i     (ex2mem_reg_wen),
    .mem_waddr_i   (ex2mem_reg_waddr),
    .hazard_o      (hazard),
    .rs1_fwd_mem_o (f1m),
    .rs1_fwd_wb_o  (f1w),
    .rs2_fwd_mem_o (f2m),
    .rs2_fwd_wb_o  (f2w)
  );

  // flush redirects IF, so it overrides the load-use hold on id_ready
  always_comb begin
    valid_d  = if2id_valid && !hazard && !flush;
    id_ready = !rst && !ex_stall && (flush || !hazard);
  end

  // register file written from WB; x0 is never written
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**RF_AW; i++) rf_q[i] <= '0;
    end else if (reg_wen && |reg_waddr) begin
      rf_q[reg_waddr] <= reg_wdata;
    end
  end

  // ID/EX register: advance unless EX stalls; control bits qualified by the incoming valid
  always_ff @(posedge clk) begin
    if (rst) begin
      {valid_q, wen_q, mem_read_q, sel_imm_q, ill_q, f1m_q, f1w_q, f2m_q, f2w_q} <= '0;
      pc_q       <= '0;
      waddr_q    <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      alu_op_q   <= '0;
    end else if (!ex_stall) begin
      valid_q    <= valid_d;
      pc_q       <= if2id_pc;
      wen_q      <= dec.reg_wen && valid_d;
      waddr_q    <= rd;
      mem_read_q <= dec.mem_read && valid_d;
      rs1_data_q <= rs1_data;
      rs2_data_q <= rs2_data;
      imm_q      <= IMM_W'(dec.imm);
      alu_op_q   <= ALU_OP_W'(dec.alu_op);
      sel_imm_q  <= dec.sel_imm;
      ill_q      <= dec.ill && valid_d;
      f1m_q      <= f1m && valid_d;
      f1w_q      <= f1w && valid_d;
      f2m_q      <= f2m && valid_d;
      f2w_q      <= f2w && valid_d;
    end else if (flush) begin
      valid_q    <= 1'b0;
      wen_q      <= 1'b0;
      mem_read_q <= 1'b0;
      ill_q      <= 1'b0;
    end
  end

  assign id2ex_valid                = valid_q;
  assign id2ex_pc                   = pc_q;
  assign id2ex_reg_wen              = wen_q;
  assign id2ex_reg_waddr            = waddr_q;
  assign id2ex_mem_read             = mem_read_q;
  assign id2ex_reg_rs1_data         = rs1_data_q;
  assign id2ex_reg_rs2_data         = rs2_data_q;
  assign id2ex_imm_value            = imm_q;
  assign id2ex_alu_op               = alu_op_q;
  assign id2ex_sel_imm              = sel_imm_q;
  assign id2ex_rs1_forward_from_mem = f1m_q;
  assign id2ex_rs1_forward_from_wb  = f1w_q;
  assign id2ex_rs2_forward_from_mem = f2m_q;
  assign id2ex_rs2_forward_from_wb  = f2w_q;
  assign id2ex_ill_instr            = ill_q;

endmodule

// File: tb/tb_id_stage_hs.sv
// tb_id_stage_hs: directed and random checks of id_stage_hs against a behavioural model
module tb_id_stage_hs;

`ifdef ID_LOAD_USE_STALL_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic        clk, rst, if2id_valid, id_ready, ex_stall, flush, ex2mem_reg_wen, reg_wen;
  logic [31:0] if2id_pc, if2id_instruction, reg_wdata;
  logic [4:0]  ex2mem_reg_waddr, reg_waddr;
  logic        id2ex_valid, id2ex_reg_wen, id2ex_mem_read, id2ex_sel_imm, id2ex_ill_instr;
  logic        id2ex_rs1_forward_from_mem, id2ex_rs1_forward_from_wb, id2ex_rs2_forward_from_mem, id2ex_rs2_forward_from_wb;
  logic [31:0] id2ex_pc, id2ex_reg_rs1_data, id2ex_reg_rs2_data, id2ex_imm_value;
  logic [4:0]  id2ex_reg_waddr;
  logic [3:0]  id2ex_alu_op;

  id_stage_hs dut (
    .clk(clk), .rst(rst), .if2id_valid(if2id_valid), .if2id_pc(if2id_pc), .if2id_instruction(if2id_instruction),
    .id_ready(id_ready), .ex_stall(ex_stall), .flush(flush), .ex2mem_reg_waddr(ex2mem_reg_waddr),
    .ex2mem_reg_wen(ex2mem_reg_wen), .reg_wen(reg_wen), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .id2ex_valid(id2ex_valid), .id2ex_pc(id2ex_pc), .id2ex_reg_wen(id2ex_reg_wen), .id2ex_reg_waddr(id2ex_reg_waddr),
    .id2ex_mem_read(id2ex_mem_read), .id2ex_reg_rs1_data(id2ex_reg_rs1_data), .id2ex_reg_rs2_data(id2ex_reg_rs2_data),
    .id2ex_imm_value(id2ex_imm_value), .id2ex_alu_op(id2ex_alu_op), .id2ex_sel_imm(id2ex_sel_imm),
    .id2ex_rs1_forward_from_mem(id2ex_rs1_forward_from_mem), .id2ex_rs1_forward_from_wb(id2ex_rs1_forward_from_wb),
    .id2ex_rs2_forward_from_mem(id2ex_rs2_forward_from_mem), .id2ex_rs2_forward_from_wb(id2ex_rs2_forward_from_wb),
    .id2ex_ill_instr(id2ex_ill_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  // reference state: architectural registers and the contents of the ID/EX slot
  logic [31:0] rf [32];
  logic        q_valid, q_wen, q_mr, q_sel, q_ill, q_f1m, q_f1w, q_f2m, q_f2w;
  logic [31:0] q_pc, q_d1, q_d2, q_imm;
  logic [4:0]  q_waddr;
  logic [3:0]  q_alu;
  // next-slot values computed from the current inputs
  logic        n_valid, n_wen, n_mr, n_sel, n_ill, n_f1m, n_f1w, n_f2m, n_f2w, e_ready, acc, ready_pre;
  logic [31:0] n_d1, n_d2, n_imm;
  logic [4:0]  n_waddr;
  logic [3:0]  n_alu;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sx12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  function automatic logic [31:0] rd_rf(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (reg_wen && reg_waddr == a) return reg_wdata;
    return rf[a];
  endfunction

  task automatic model_eval();
    logic [31:0] i;
    logic is_r, is_i, is_ld, is_st, legal, haz;
    logic [4:0] r1, r2, d;
    i     = if2id_instruction;
    is_r  = i[6:0] == 7'h33;
    is_i  = i[6:0] == 7'h13;
    is_ld = i[6:0] == 7'h03;
    is_st = i[6:0] == 7'h23;
    legal = is_r || is_i || is_ld || is_st;
    r1    = legal ? i[19:15] : 5'd0;
    r2    = (is_r || is_st) ? i[24:20] : 5'd0;
    d     = (is_r || is_i || is_ld) ? i[11:7] : 5'd0;
    haz   = HZ && q_valid && q_mr && q_waddr != 0 && ((r1 != 0 && r1 == q_waddr) || (r2 != 0 && r2 == q_waddr));
    e_ready = !rst && !ex_stall && (flush || !haz);
    acc     = if2id_valid && e_ready;
    n_valid = if2id_valid && !haz && !flush;
    n_waddr = d;
    n_wen   = d != 0 && n_valid;
    n_mr    = is_ld && n_valid;
    n_ill   = !legal && n_valid;
    n_sel   = is_i || is_ld || is_st;
    n_alu   = (is_r && i[30]) ? 4'h8 : 4'h0;
    n_imm   = (is_i || is_ld) ? sx12(i[31:20]) : is_st ? sx12({i[31:25], i[11:7]}) : 32'd0;
    n_d1    = rd_rf(r1);
    n_d2    = rd_rf(r2);
    n_f1m   = r1 != 0 && r1 == q_waddr && q_wen && q_valid;
    n_f2m   = r2 != 0 && r2 == q_waddr && q_wen && q_valid;
    n_f1w   = r1 != 0 && r1 == ex2mem_reg_waddr && ex2mem_reg_wen && !n_f1m && n_valid;
    n_f2w   = r2 != 0 && r2 == ex2mem_reg_waddr && ex2mem_reg_wen && !n_f2m && n_valid;
    n_f1m   = n_f1m && n_valid;
    n_f2m   = n_f2m && n_valid;
  endtask

  task automatic model_commit();
    if (rst) begin
      for (int k = 0; k < 32; k++) rf[k] = 32'd0;
      {q_valid, q_wen, q_mr, q_sel, q_ill, q_f1m, q_f1w, q_f2m, q_f2w} = '0;
      {q_pc, q_d1, q_d2, q_imm, q_waddr, q_alu} = '0;
    end else begin
      if (reg_wen && reg_waddr != 0) rf[reg_waddr] = reg_wdata;
      if (!ex_stall) begin
        q_valid = n_valid; q_pc = if2id_pc; q_wen = n_wen; q_waddr = n_waddr; q_mr = n_mr;
        q_d1 = n_d1; q_d2 = n_d2; q_imm = n_imm; q_alu = n_alu; q_sel = n_sel; q_ill = n_ill;
        q_f1m = n_f1m; q_f1w = n_f1w; q_f2m = n_f2m; q_f2w = n_f2w;
      end else if (flush) begin
        q_valid = 1'b0; q_wen = 1'b0; q_mr = 1'b0; q_ill = 1'b0;
      end
    end
  endtask

  task automatic chk_all();
    chk("valid", 32'(id2ex_valid), 32'(q_valid));
    chk("pc", id2ex_pc, q_pc);
    chk("reg_wen", 32'(id2ex_reg_wen), 32'(q_wen));
    chk("reg_waddr", 32'(id2ex_reg_waddr), 32'(q_waddr));
    chk("mem_read", 32'(id2ex_mem_read), 32'(q_mr));
    chk("rs1_data", id2ex_reg_rs1_data, q_d1);
    chk("rs2_data", id2ex_reg_rs2_data, q_d2);
    chk("imm", id2ex_imm_value, q_imm);
    chk("alu_op", 32'(id2ex_alu_op), 32'(q_alu));
    chk("sel_imm", 32'(id2ex_sel_imm), 32'(q_sel));
    chk("ill", 32'(id2ex_ill_instr), 32'(q_ill));
    chk("rs1_fwd_mem", 32'(id2ex_rs1_forward_from_mem), 32'(q_f1m));
    chk("rs1_fwd_wb", 32'(id2ex_rs1_forward_from_wb), 32'(q_f1w));
    chk("rs2_fwd_mem", 32'(id2ex_rs2_forward_from_mem), 32'(q_f2m));
    chk("rs2_fwd_wb", 32'(id2ex_rs2_forward_from_wb), 32'(q_f2w));
  endtask

  // one clock: check id_ready on current inputs, then the registered outputs after the edge
  task automatic cyc();
    #1;
    model_eval();
    ready_pre = id_ready;
    chk("id_ready", 32'(id_ready), 32'(e_ready));
    @(posedge clk);
    model_commit();
    #1;
    chk_all();
  endtask

  function automatic logic [31:0] op_r(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1, input logic [4:0] d);
    return {f7, s2, s1, 3'b000, d, 7'h33};
  endfunction
  function automatic logic [31:0] op_i(input logic [11:0] im, input logic [4:0] s1, input logic [4:0] d);
    return {im, s1, 3'b000, d, 7'h13};
  endfunction
  function automatic logic [31:0] op_lw(input logic [11:0] im, input logic [4:0] s1, input logic [4:0] d);
    return {im, s1, 3'b010, d, 7'h03};
  endfunction
  function automatic logic [31:0] op_sw(input logic [11:0] im, input logic [4:0] s2, input logic [4:0] s1);
    return {im[11:5], s2, s1, 3'b010, im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [4:0] a, b, c;
    logic [11:0] im;
    a  = 5'($urandom_range(0, 7));
    b  = 5'($urandom_range(0, 7));
    c  = 5'($urandom_range(0, 7));
    im = 12'($urandom);
    case ($urandom_range(0, 5))
      0: return op_r(7'h00, b, a, c);
      1: return op_r(7'h20, b, a, c);
      2: return op_i(im, a, c);
      3: return op_lw(im, a, c);
      4: return op_sw(im, b, a);
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    {ex_stall, flush, ex2mem_reg_wen, reg_wen} = '0;
    ex2mem_reg_waddr = '0; reg_waddr = '0; reg_wdata = '0;
    {q_valid, q_wen, q_mr, q_sel, q_ill, q_f1m, q_f1w, q_f2m, q_f2w} = '0;
    {q_pc, q_d1, q_d2, q_imm, q_waddr, q_alu} = '0;
    for (int k = 0; k < 32; k++) rf[k] = 32'd0;

    // reset held two cycles with an instruction waiting
    rst = 1'b1; if2id_valid = 1'b1; if2id_pc = 32'h100; if2id_instruction = op_i(12'd5, 5'd0, 5'd1);
    cyc(); cyc();
    chk("t1_rst_ready", 32'(ready_pre), 32'd0);
    chk("t1_rst_valid", 32'(id2ex_valid), 32'd0);
    rst = 1'b0;
    cyc();
    chk("t1_release_valid", 32'(id2ex_valid), 32'd1);

    // load-use: one bubble, then the consumer forwards from WB
    if2id_pc = 32'h200; if2id_instruction = op_lw(12'd0, 5'd1, 5'd5); cyc();
    if2id_pc = 32'h204; if2id_instruction = op_r(7'h00, 5'd2, 5'd5, 5'd6); cyc();
    chk("t2_ready", 32'(ready_pre), 32'(!HZ));
    chk("t2_bubble", 32'(id2ex_valid), 32'(!HZ));
    ex2mem_reg_waddr = 5'd5; ex2mem_reg_wen = 1'b1; cyc();
    chk("t2_ready_after", 32'(ready_pre), 32'd1);
    chk("t2_valid_after", 32'(id2ex_valid), 32'd1);
    chk("t2_rs1_fwd_wb", 32'(id2ex_rs1_forward_from_wb), 32'd1);
    chk("t2_rs1_fwd_mem", 32'(id2ex_rs1_forward_from_mem), 32'd0);

    // back-to-back dependency forwards from MEM, which beats WB; rd=x0 never forwards
    if2id_pc = 32'h208; if2id_instruction = op_r(7'h00, 5'd2, 5'd1, 5'd3); cyc();
    ex2mem_reg_waddr = 5'd3;
    if2id_pc = 32'h20c; if2id_instruction = op_r(7'h20, 5'd3, 5'd3, 5'd4); cyc();
    chk("t3_rs1_mem", 32'(id2ex_rs1_forward_from_mem), 32'd1);
    chk("t3_rs2_mem", 32'(id2ex_rs2_forward_from_mem), 32'd1);
    chk("t3_rs1_wb", 32'(id2ex_rs1_forward_from_wb), 32'd0);
    chk("t3_rs2_wb", 32'(id2ex_rs2_forward_from_wb), 32'd0);
    chk("t3_alu_sub", 32'(id2ex_alu_op), 32'h8);
    if2id_pc = 32'h210; if2id_instruction = op_r(7'h00, 5'd2, 5'd1, 5'd0); cyc();
    chk("t3_x0_wen", 32'(id2ex_reg_wen), 32'd0);
    ex2mem_reg_waddr = 5'd0;
    if2id_pc = 32'h214; if2id_instruction = op_r(7'h20, 5'd3, 5'd3, 5'd4); cyc();
    chk("t3_x0_flags", 32'({id2ex_rs1_forward_from_mem, id2ex_rs1_forward_from_wb,
                            id2ex_rs2_forward_from_mem, id2ex_rs2_forward_from_wb}), 32'd0);

    // WB write-through on the same cycle, then read back from the regfile
    ex2mem_reg_wen = 1'b0;
    reg_wen = 1'b1; reg_waddr = 5'd7; reg_wdata = 32'hDEADBEEF;
    if2id_pc = 32'h218; if2id_instruction = op_i(12'd1, 5'd7, 5'd8); cyc();
    chk("t4_bypass", id2ex_reg_rs1_data, 32'hDEADBEEF);
    chk("t4_imm", id2ex_imm_value, 32'd1);
    reg_wen = 1'b0;
    if2id_pc = 32'h21c; if2id_instruction = op_r(7'h00, 5'd7, 5'd7, 5'd9); cyc();
    chk("t4_rf_rs2", id2ex_reg_rs2_data, 32'hDEADBEEF);

    // EX stall holds the slot; flush during stall kills it
    if2id_pc = 32'h300; if2id_instruction = op_i(12'h055, 5'd0, 5'd10); cyc();
    ex_stall = 1'b1;
    if2id_pc = 32'h304; if2id_instruction = op_r(7'h00, 5'd10, 5'd10, 5'd11);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t5_stall_ready", 32'(ready_pre), 32'd0);
      chk("t5_stall_pc", id2ex_pc, 32'h300);
      chk("t5_stall_valid", 32'(id2ex_valid), 32'd1);
    end
    flush = 1'b1; cyc();
    chk("t5_flush_valid", 32'(id2ex_valid), 32'd0);
    ex_stall = 1'b0; flush = 1'b0; cyc();
    chk("t5_resume_pc", id2ex_pc, 32'h304);

    // flush coincident with a load-use hazard
    if2id_pc = 32'h400; if2id_instruction = op_lw(12'd0, 5'd1, 5'd5); cyc();
    flush = 1'b1; if2id_pc = 32'h404; if2id_instruction = op_r(7'h00, 5'd2, 5'd5, 5'd6); cyc();
    chk("t6_ready", 32'(ready_pre), 32'd1);
    chk("t6_valid", 32'(id2ex_valid), 32'd0);
    flush = 1'b0; if2id_pc = 32'h408; if2id_instruction = op_i(12'd7, 5'd0, 5'd12); cyc();
    chk("t6_no_bubble", 32'(id2ex_valid), 32'd1);
    chk("t6_illegal_none", 32'(id2ex_ill_instr), 32'd0);

    // random traffic; IF holds an instruction until it is accepted
    for (int n = 0; n < 400; n++) begin
      if (!(if2id_valid && !acc)) begin
        if2id_valid       = $urandom_range(0, 3) != 0;
        if2id_instruction = rnd_instr();
        if2id_pc          = if2id_pc + 32'd4;
      end
      ex_stall         = $urandom_range(0, 4) == 0;
      flush            = $urandom_range(0, 9) == 0;
      ex2mem_reg_waddr = 5'($urandom_range(0, 7));
      ex2mem_reg_wen   = $urandom_range(0, 1) == 1;
      reg_wen          = $urandom_range(0, 1) == 1;
      reg_waddr        = 5'($urandom_range(0, 7));
      reg_wdata        = $urandom;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
